// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and helpers for the key pulse generator
package key_pkg;

    localparam logic KEY_PRESSED  = 1'b1;
    localparam logic KEY_RELEASED = 1'b0;

    // A one-bit counter is the minimum even when DB_CYCLES is tiny.
    function automatic int cnt_width(input int db_cycles);
        int w;
        w = $clog2(db_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key channel: polarity normalise, 2-flop sync, debounce, rise detect
module key_debounce
    import key_pkg::*;
#(
    parameter int DB_CYCLES      = 1000000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          norm;
    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    assign norm = KEY_ACTIVE_LOW ? ~raw : raw;

    // Synchronizer resets to the released level so reset alone never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= KEY_RELEASED;
            s2       <= KEY_RELEASED;
            stable   <= KEY_RELEASED;
            stable_d <= KEY_RELEASED;
            cnt      <= '0;
        end else begin
            s1       <= norm;
            s2       <= s1;
            stable_d <= stable;
            if (s2 != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = stable;
    assign press = stable & ~stable_d;

endmodule

// File: rtl/key_pulse_gen.sv
// rtl/key_pulse_gen.sv - two debounced keys into mutually exclusive single-cycle press pulses
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int DB_CYCLES      = 1000000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_raw,
    output logic       k0,
    output logic       k1,
    output logic [1:0] key_level
);

    logic level0;
    logic level1;
    logic press0;
    logic press1;
    logic pend1;

    key_debounce #(
        .DB_CYCLES      (DB_CYCLES),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_db0 (
        .clk   (clk),
        .rst   (rst),
        .raw   (key_raw[0]),
        .level (level0),
        .press (press0)
    );

    key_debounce #(
        .DB_CYCLES      (DB_CYCLES),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_db1 (
        .clk   (clk),
        .rst   (rst),
        .raw   (key_raw[1]),
        .level (level1),
        .press (press1)
    );

    // Key 0 wins a collision; key 1 is parked in pend1 and issued the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            k0    <= 1'b0;
            k1    <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            k0    <= press0;
            k1    <= (press1 | pend1) & ~press0;
            pend1 <= (press1 | pend1) & press0;
        end
    end

    assign key_level = {level1, level0};

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb/tb_key_pulse_gen.sv - scoreboard bench for key_pulse_gen
module tb_key_pulse_gen;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    typedef struct {
        int key;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_raw = 2'b11;
    logic       k0;
    logic       k1;
    logic [1:0] key_level;

    exp_t sb[$];
    exp_t mon_e;
    int   edge_cnt = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    key_pulse_gen #(
        .DB_CYCLES      (DB),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw),
        .k0        (k0),
        .k1        (k1),
        .key_level (key_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int key, input int delay);
        exp_t e;
        e.key = key;
        e.cyc = edge_cnt + delay;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (k0 !== 1'b0 || k1 !== 1'b0) begin
            check("k0_k1_exclusive", 32'(k0 & k1), 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({k1, k0}), 0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_key", k1 ? 1 : 0, mon_e.key);
                check("pulse_cycle", edge_cnt, mon_e.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        key_raw = 2'b11;
        tick(3);
        check("reset_k0", 32'(k0), 0);
        check("reset_k1", 32'(k1), 0);
        check("reset_level", 32'(key_level), 0);
        rst = 1'b0;
        tick(20);
        check("idle_level", 32'(key_level), 0);

        // clean press of key 0
        key_raw = 2'b10;
        expect_pulse(0, LAT);
        tick(DB + 1);
        check("level_before_accept", 32'(key_level), 0);
        tick(1);
        check("level_after_accept", 32'(key_level), 1);
        tick(10);
        key_raw = 2'b11;
        tick(12);
        check("level_after_release", 32'(key_level), 0);

        // bounce on press and on release
        key_raw = 2'b10;
        tick(2);
        key_raw = 2'b11;
        tick(2);
        key_raw = 2'b10;
        expect_pulse(0, LAT);
        tick(12);
        check("level_bounce_press", 32'(key_level), 1);
        key_raw = 2'b11;
        tick(2);
        key_raw = 2'b10;
        tick(2);
        check("level_during_release_bounce", 32'(key_level), 1);
        key_raw = 2'b11;
        tick(12);
        check("level_bounce_release", 32'(key_level), 0);

        // simultaneous press: k0 then k1 on the following cycle
        key_raw = 2'b00;
        expect_pulse(0, LAT);
        expect_pulse(1, LAT + 1);
        tick(12);
        check("level_both", 32'(key_level), 3);
        key_raw = 2'b11;
        tick(12);
        check("level_both_release", 32'(key_level), 0);

        // key 1 long hold, release, press again
        key_raw = 2'b01;
        expect_pulse(1, LAT);
        tick(50);
        check("level_k1_hold", 32'(key_level), 2);
        key_raw = 2'b11;
        tick(10);
        check("level_k1_release", 32'(key_level), 0);
        key_raw = 2'b01;
        expect_pulse(1, LAT);
        tick(12);
        check("level_k1_repress", 32'(key_level), 2);
        key_raw = 2'b11;
        tick(12);

        // reset in the middle of a debounce with key still held
        key_raw = 2'b10;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_k0", 32'(k0), 0);
        check("midrst_level", 32'(key_level), 0);
        expect_pulse(0, LAT);
        tick(15);
        check("midrst_level_after", 32'(key_level), 1);
        key_raw = 2'b11;
        tick(12);

        check("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
